// File: rtl/tile_feeder_pkg.sv
// rtl/tile_feeder_pkg.sv - shared tile types, bag constants and feeder states
package tetris;

  typedef enum logic [2:0] {eNon, eI, eJ, eL, eO, eS, eT, eZ} tile_type_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          BAG_SIZE  = 7;

  typedef struct packed {
    tile_type_e  tile_type;
    logic [1:0]  angle;
  } bag_entry_t;

  typedef enum logic [1:0] {eIDLE, eWAIT, eOFFER} feeder_state_e;

  // Bag index i maps to the i-th shape after eNon.
  function automatic tile_type_e shape_of(logic [2:0] idx);
    return tile_type_e'(idx + 3'd1);
  endfunction

endpackage

// File: rtl/tile_bag_lfsr.sv
// rtl/tile_bag_lfsr.sv - Galois LFSR plus 7-bag draw; angle randomised under TILE_FEEDER_RAND_ANGLE_EN
module tile_bag_lfsr
  import tetris::*;
#(
  parameter logic [15:0] seed_p = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        draw_i,
  input  logic        seed_v_i,
  input  logic [15:0] seed_i,
  output bag_entry_t  entry_o
);

  logic [15:0] lfsr;
  logic [6:0]  used;
  logic [6:0]  used_next;
  logic [2:0]  start;
  logic [2:0]  pick;
  logic        found;

  // First unused slot scanning upward from the LFSR-chosen start, wrapping at 7.
  always_comb begin
    start     = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
    pick      = start;
    found     = 1'b0;
    for (int k = 0; k < BAG_SIZE; k++) begin
      int j;
      j = (int'(start) + k) % BAG_SIZE;
      if (!found && !used[j]) begin
        pick  = 3'(j);
        found = 1'b1;
      end
    end
    used_next = used | (7'b1 << pick);
    if (used_next == 7'h7F) used_next = 7'h00;
  end

  assign entry_o.tile_type = shape_of(pick);
`ifdef TILE_FEEDER_RAND_ANGLE_EN
  assign entry_o.angle = lfsr[9:8];
`else
  assign entry_o.angle = 2'b00;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr <= seed_p;
      used <= 7'h00;
    end else if (seed_v_i) begin
      lfsr <= (seed_i == 16'h0000) ? seed_p : seed_i;
      used <= 7'h00;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      if (draw_i) used <= used_next;
    end
  end

endmodule

// File: rtl/tile_feeder.sv
// rtl/tile_feeder.sv - preview queue and spawn handshake FSM; optional TILE_FEEDER_RAND_ANGLE_EN
module tile_feeder
  import tetris::*;
#(
  parameter int          preview_p = 3,
  parameter logic [15:0] seed_p    = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_i,
  input  logic        seed_v_i,
  input  logic [15:0] seed_i,
  input  logic        ready_i,
  output logic        v_o,
  output tile_type_e  tile_type_o,
  output logic [1:0]  tile_type_angle_o,
  output tile_type_e  preview_o,
  output logic        busy_o
);

  localparam int PW = (preview_p > 1) ? $clog2(preview_p) : 1;
  localparam int CW = $clog2(preview_p + 1);

  feeder_state_e  state;
  bag_entry_t     entry;
  tile_type_e     q_type [preview_p];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty, push, pop;
  logic [1:0]     head_angle;

  assign full  = (count == CW'(preview_p));
  assign empty = (count == '0);
  assign push  = !full && !seed_v_i;
  assign pop   = !empty && !seed_v_i &&
                 ((state == eIDLE && req_i) || state == eWAIT);

  tile_bag_lfsr #(.seed_p(seed_p)) u_bag (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .draw_i    (push),
    .seed_v_i  (seed_v_i),
    .seed_i    (seed_i),
    .entry_o   (entry)
  );

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(preview_p - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef TILE_FEEDER_RAND_ANGLE_EN
  logic [1:0] q_angle [preview_p];
  always_ff @(posedge clk_i) if (push) q_angle[wr_ptr] <= entry.angle;
  assign head_angle = q_angle[rd_ptr];
`else
  logic unused_angle;
  assign unused_angle = ^entry.angle;
  assign head_angle   = 2'b00;
`endif

  always_ff @(posedge clk_i) if (push) q_type[wr_ptr] <= entry.tile_type;

  assign preview_o = empty ? eNon : q_type[rd_ptr];
  assign busy_o    = (state != eIDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state             <= eIDLE;
      v_o               <= 1'b0;
      tile_type_o       <= eNon;
      tile_type_angle_o <= 2'b00;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
    end else begin
      if (seed_v_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
      // A cancelled pop (seed cycle) from eIDLE still parks in eWAIT.
      case (state)
        eIDLE, eWAIT: begin
          if (pop) begin
            tile_type_o       <= q_type[rd_ptr];
            tile_type_angle_o <= head_angle;
            v_o               <= 1'b1;
            state             <= eOFFER;
          end else if (req_i || state == eWAIT) begin
            state <= eWAIT;
          end
        end
        eOFFER: begin
          if (ready_i) begin
            v_o   <= 1'b0;
            state <= eIDLE;
          end
        end
        default: state <= eIDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_feeder.sv
// tb/tb_tile_feeder.sv - directed bench for tile_feeder; honours TILE_FEEDER_RAND_ANGLE_EN
module tb_tile_feeder;
  import tetris::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        seed_v = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        ready = 1'b0;
  logic        v;
  tile_type_e  tt;
  logic [1:0]  ang;
  tile_type_e  pv;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic req;
    logic ready;
    logic exp_v;
    logic exp_busy;
  } vec_t;

  vec_t        tbl [8];
  tile_type_e  got_t [14];
  logic [1:0]  got_a [14];
  tile_type_e  ref_t [14];
  logic [1:0]  ref_a [14];
  tile_type_e  s1_t  [7];
  tile_type_e  first3 [3];
  logic [1:0]  exp_a [3];
  tile_type_e  pv_before;
  logic [7:0]  mask;

  always #5 clk = ~clk;

  tile_feeder dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .req_i             (req),
    .seed_v_i          (seed_v),
    .seed_i            (seed),
    .ready_i           (ready),
    .v_o               (v),
    .tile_type_o       (tt),
    .tile_type_angle_o (ang),
    .preview_o         (pv),
    .busy_o            (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int k, output tile_type_e t, output logic [1:0] a);
    req   = 1'b1;
    ready = 1'b1;
    step();
    req = 1'b0;
    chk($sformatf("lat_v%0d", k), v, 1);
    t = tt;
    a = ang;
    step();
    chk($sformatf("drop_v%0d", k), v, 0);
    chk($sformatf("idle_busy%0d", k), busy, 0);
    ready = 1'b0;
  endtask

  task automatic run_seq(input int n, input tile_type_e exp_pv);
    step();
    chk("first_push_pv", pv, exp_pv);
    repeat (4) step();
    chk("filled_v", v, 0);
    chk("filled_busy", busy, 0);
    chk("filled_pv", pv, exp_pv);
    for (int i = 0; i < n; i++) xfer(i, got_t[i], got_a[i]);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
    first3[0] = eJ; first3[1] = eI; first3[2] = eL;
`ifdef TILE_FEEDER_RAND_ANGLE_EN
    exp_a[0] = 2'd0; exp_a[1] = 2'd2; exp_a[2] = 2'd1;
`else
    exp_a[0] = 2'd0; exp_a[1] = 2'd0; exp_a[2] = 2'd0;
`endif

    #2;
    chk("rst_v", v, 0);
    chk("rst_type", tt, eNon);
    chk("rst_angle", ang, 0);
    chk("rst_pv", pv, eNon);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    run_seq(14, eJ);
    for (int i = 0; i < 14; i++) begin
      ref_t[i] = got_t[i];
      ref_a[i] = got_a[i];
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("first_type%0d", i), ref_t[i], first3[i]);
      chk($sformatf("first_angle%0d", i), ref_a[i], exp_a[i]);
    end
    for (int g = 0; g < 2; g++) begin
      mask = 8'h00;
      for (int i = 0; i < 7; i++) mask[ref_t[g*7+i]] = 1'b1;
      chk($sformatf("bag_group%0d", g), mask, 8'hFE);
    end

    pv_before = pv;
    for (int i = 0; i < 8; i++) begin
      req   = tbl[i].req;
      ready = tbl[i].ready;
      step();
      chk($sformatf("stall_v%0d", i), v, tbl[i].exp_v);
      chk($sformatf("stall_busy%0d", i), busy, tbl[i].exp_busy);
      chk($sformatf("stall_type%0d", i), tt, pv_before);
    end
    req   = 1'b0;
    ready = 1'b0;

    seed_v = 1'b1; seed = 16'h0000;
    step();
    seed_v = 1'b0;
    run_seq(7, eJ);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("seed0_type%0d", i), got_t[i], ref_t[i]);
      chk($sformatf("seed0_angle%0d", i), got_a[i], ref_a[i]);
    end

    seed_v = 1'b1; seed = 16'h1234;
    step();
    seed_v = 1'b0;
    run_seq(7, eS);
    for (int i = 0; i < 7; i++) s1_t[i] = got_t[i];
    seed_v = 1'b1;
    step();
    seed_v = 1'b0;
    run_seq(7, eS);
    for (int i = 0; i < 7; i++) chk($sformatf("seed1234_type%0d", i), got_t[i], s1_t[i]);

    req = 1'b1; seed_v = 1'b1; seed = 16'h1234;
    step();
    req = 1'b0; seed_v = 1'b0;
    chk("sr_busy0", busy, 1);
    chk("sr_v0", v, 0);
    chk("sr_pv0", pv, eNon);
    step();
    chk("sr_v1", v, 0);
    chk("sr_busy1", busy, 1);
    chk("sr_pv1", pv, eS);
    step();
    chk("sr_v2", v, 1);
    chk("sr_type2", tt, eS);
    ready = 1'b1;
    step();
    chk("sr_done_v", v, 0);
    chk("sr_done_busy", busy, 0);
    ready = 1'b0;

    req = 1'b1;
    step();
    req = 1'b0;
    chk("pre_rst_v", v, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_v", v, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_type", tt, eNon);
    chk("async_rst_pv", pv, eNon);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
